alu_register_file: RTL and testbench
====================================

# alu_register_file

32 x 32-bit register file that supplies both operands to the 32-bit ALU (A from read port 1, B from read port 2) and accepts the write-back result. Register 0 is hardwired to zero. Writes are synchronous and reads are combinational. A same-cycle write is forwarded to the read ports, so the ALU sees a just-written value without a one-cycle bubble.

## Interface
- DATA_WIDTH, 32, register and port data width; fixed by the ALU datapath.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH = 32.

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- read_reg1  input  ADDR_WIDTH  index for read port 1, which drives ALU operand A.
- read_reg2  input  ADDR_WIDTH  index for read port 2, which drives ALU operand B.
- write_reg  input  ADDR_WIDTH  destination index for write-back.
- write_data  input  DATA_WIDTH  write-back value (ALU result).
- reg_write  input  1  write enable, sampled at rising edge.
- read_data1  output  DATA_WIDTH  contents for read_reg1, with forwarding.
- read_data2  output  DATA_WIDTH  contents for read_reg2, with forwarding.

## Operation
- Storage: 31 physical 32-bit registers, indices 1..31. Index 0 has no storage and always reads 0.
- Write:
  - Occurs at a rising edge of clk when rst_n=1, reg_write=1 and write_reg!=0.
  - A write to index 0 is silently discarded.
- Reset:
  - At a rising edge with rst_n=0, all registers 1..31 clear to 0x00000000.
  - Any write presented in that cycle is ignored.
  - Reset takes priority over reg_write.
- Read, per port independently, evaluated combinationally:
  - rst_n=0: output 0x00000000.
  - else index==0: 0x00000000.
  - else reg_write=1 and write_reg==index: write_data (forward).
  - else stored register value.
- Both ports may address the same register. Both then return identical values, including under forwarding.
- No other state exists: no read side effects and no read enables.

## Timing
- Read latency is 0 cycles, combinational from read_reg*, write_reg, write_data, reg_write and rst_n.
- Write latency:
  - The stored value updates at the rising edge that samples reg_write=1.
  - Through forwarding, the new value is visible on read ports in the same cycle it is presented.
  - After the edge it comes from storage.
- Reset values: all registers 0. Both read outputs are 0 while rst_n=0 and remain 0 afterwards until a register is written.
- Reset asserted mid-operation, e.g. a write pending in the same cycle:
  - The write is lost.
  - The next cycle reads 0 from every index.
- Deassertion: the first write is accepted at the first rising edge with rst_n=1.
- Back-to-back writes to the same index on consecutive cycles: the last one wins. Each value is visible through forwarding in its own cycle.
- Forwarding is a required feature, not an optional optimisation. The verifier checks read_data in the same cycle as the write.

## Test plan
- Reset clears all registers:
  - Stimulus: write 0xFFFFFFFF to all indices 1..31, then rst_n=0 for one edge, then read every index on both ports.
  - Required: all reads return 0x00000000. While rst_n=0 both outputs are 0 regardless of index.
- Register 0 is immutable:
  - Stimulus: reg_write=1, write_reg=0, write_data=0xDEADBEEF. Read index 0 on both ports, both in that cycle and the next.
  - Required: 0x00000000 in both cycles. No forwarding applies to index 0.
- Write then read, all indices:
  - Stimulus: write (0x01010101 * i) to index i for i=1..31, one per cycle. Then read pairs (i, 32-i).
  - Required: read_data1=0x01010101*i and read_data2=0x01010101*(32-i).
- Same-cycle forwarding:
  - Setup: index 7 holds 0x0000000F.
  - Stimulus: reg_write=1, write_reg=7, write_data=0x12345678, with read_reg1=read_reg2=7.
  - Required: both outputs are 0x12345678 in that cycle, and the stored value reads 0x12345678 after the edge.
- Write-enable and priority:
  - Stimulus A: reg_write=0 with write_reg=3, write_data=0xAAAAAAAA. Required: index 3 is unchanged and no forwarding occurs.
  - Stimulus B: reg_write=1 with rst_n=0, write_reg=3, write_data=0x55555555. Required: index 3 reads 0 after the edge.
- ALU pairing:
  - Setup: index 8 holds 0xF0F0F0F0 and index 9 holds 0x0FF00FF0.
  - Stimulus: read_reg1=8, read_reg2=9, with the outputs driving the 32-bit AND.
  - Required: operands are presented unchanged, so the AND produces 0x00F000F0.

Source files
------------

// File: rtl/alu_register_file.sv
// Register file feeding both ALU operands: r0 reads as zero, writes land on the rising edge,
// and a write presented this cycle is forwarded straight to the read ports.
module alu_register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  // Index 0 has no storage; physical registers are 1..Depth-1.
  logic [DATA_WIDTH-1:0] regs_q [1:Depth-1];
  logic [DATA_WIDTH-1:0] regs_d [1:Depth-1];
  logic                  wr_en;

  assign wr_en = reg_write && (write_reg != '0);

  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 1; i < Depth; i++) begin
      if (wr_en && (write_reg == ADDR_WIDTH'(i))) begin
        regs_d[i] = write_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reset and r0 override forwarding; forwarding overrides storage.
  always_comb begin
    read_data1 = '0;
    if (rst_n && (read_reg1 != '0)) begin
      if (wr_en && (write_reg == read_reg1)) begin
        read_data1 = write_data;
      end else begin
        for (int unsigned i = 1; i < Depth; i++) begin
          if (read_reg1 == ADDR_WIDTH'(i)) begin
            read_data1 = regs_q[i];
          end
        end
      end
    end
  end

  always_comb begin
    read_data2 = '0;
    if (rst_n && (read_reg2 != '0)) begin
      if (wr_en && (write_reg == read_reg2)) begin
        read_data2 = write_data;
      end else begin
        for (int unsigned i = 1; i < Depth; i++) begin
          if (read_reg2 == ADDR_WIDTH'(i)) begin
            read_data2 = regs_q[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_register_file.sv
// Directed bench for alu_register_file: reset, r0, full write/read, forwarding, priority, ALU pairing.
module tb_alu_register_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int errors = 0;
  int checks = 0;

  alu_register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .write_reg (write_reg),
    .write_data(write_data),
    .reg_write (reg_write),
    .read_data1(read_data1),
    .read_data2(read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; checks sample 1 time unit later.
  task automatic tick();
    @(negedge clk);
  endtask

  logic [31:0] exp1;
  logic [31:0] exp2;

  initial begin
    rst_n      = 1'b0;
    read_reg1  = 5'd5;
    read_reg2  = 5'd31;
    write_reg  = 5'd0;
    write_data = '0;
    reg_write  = 1'b0;
    tick();
    tick();
    #1;
    check("reset_out1", read_data1, 32'h0);
    check("reset_out2", read_data2, 32'h0);

    // Fill all registers with ones.
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      tick();
      reg_write  = 1'b1;
      write_reg  = 5'(i);
      write_data = 32'hFFFF_FFFF;
      read_reg1  = 5'(i);
      #1;
      if (i == 31) check("fill_fwd31", read_data1, 32'hFFFF_FFFF);
    end
    tick();
    reg_write = 1'b0;
    read_reg1 = 5'd12;
    read_reg2 = 5'd20;
    #1;
    check("fill_stored12", read_data1, 32'hFFFF_FFFF);
    check("fill_stored20", read_data2, 32'hFFFF_FFFF);

    // Reset with a pending write: outputs 0 during reset, write lost.
    tick();
    rst_n      = 1'b0;
    reg_write  = 1'b1;
    write_reg  = 5'd3;
    write_data = 32'h5555_5555;
    read_reg1  = 5'd3;
    read_reg2  = 5'd17;
    #1;
    check("rst_fwd_blocked", read_data1, 32'h0);
    check("rst_out2", read_data2, 32'h0);
    tick();
    rst_n     = 1'b1;
    reg_write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(31 - i);
      #1;
      check($sformatf("rst_clear_p1_%0d", i), read_data1, 32'h0);
      check($sformatf("rst_clear_p2_%0d", 31 - i), read_data2, 32'h0);
    end

    // Register 0 is immutable, no forwarding.
    tick();
    reg_write  = 1'b1;
    write_reg  = 5'd0;
    write_data = 32'hDEAD_BEEF;
    read_reg1  = 5'd0;
    read_reg2  = 5'd0;
    #1;
    check("r0_same_p1", read_data1, 32'h0);
    check("r0_same_p2", read_data2, 32'h0);
    tick();
    reg_write = 1'b0;
    #1;
    check("r0_next_p1", read_data1, 32'h0);
    check("r0_next_p2", read_data2, 32'h0);

    // Write 0x01010101*i to every index, then read pairs (i, 32-i).
    for (int i = 1; i < 32; i++) begin
      tick();
      reg_write  = 1'b1;
      write_reg  = 5'(i);
      write_data = 32'h0101_0101 * 32'(i);
    end
    tick();
    reg_write = 1'b0;
    for (int i = 1; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(32 - i);
      exp1 = 32'h0101_0101 * 32'(i);
      exp2 = 32'h0101_0101 * 32'(32 - i);
      #1;
      check($sformatf("pair_p1_%0d", i), read_data1, exp1);
      check($sformatf("pair_p2_%0d", 32 - i), read_data2, exp2);
    end

    // Same-cycle forwarding onto both ports.
    tick();
    reg_write  = 1'b1;
    write_reg  = 5'd7;
    write_data = 32'h0000_000F;
    tick();
    write_data = 32'h1234_5678;
    read_reg1  = 5'd7;
    read_reg2  = 5'd7;
    #1;
    check("fwd_p1", read_data1, 32'h1234_5678);
    check("fwd_p2", read_data2, 32'h1234_5678);
    tick();
    reg_write = 1'b0;
    #1;
    check("fwd_stored_p1", read_data1, 32'h1234_5678);
    check("fwd_stored_p2", read_data2, 32'h1234_5678);

    // Write disabled: no forward, no update.
    tick();
    reg_write  = 1'b0;
    write_reg  = 5'd3;
    write_data = 32'hAAAA_AAAA;
    read_reg1  = 5'd3;
    read_reg2  = 5'd3;
    #1;
    check("we0_nofwd", read_data1, 32'h0303_0303);
    tick();
    #1;
    check("we0_unchanged", read_data2, 32'h0303_0303);

    // Back-to-back writes to one index: last wins, each forwarded in its cycle.
    tick();
    reg_write  = 1'b1;
    write_reg  = 5'd5;
    write_data = 32'h1111_1111;
    read_reg1  = 5'd5;
    read_reg2  = 5'd6;
    #1;
    check("b2b_fwd1", read_data1, 32'h1111_1111);
    check("b2b_other", read_data2, 32'h0606_0606);
    tick();
    write_data = 32'h2222_2222;
    #1;
    check("b2b_fwd2", read_data1, 32'h2222_2222);
    tick();
    reg_write = 1'b0;
    #1;
    check("b2b_last", read_data1, 32'h2222_2222);

    // Reset beats reg_write.
    tick();
    rst_n      = 1'b0;
    reg_write  = 1'b1;
    write_reg  = 5'd3;
    write_data = 32'h5555_5555;
    tick();
    rst_n     = 1'b1;
    reg_write = 1'b0;
    read_reg1 = 5'd3;
    read_reg2 = 5'd5;
    #1;
    check("prio_r3", read_data1, 32'h0);
    check("prio_r5", read_data2, 32'h0);

    // First write after deassertion is accepted; ALU AND pairing.
    reg_write  = 1'b1;
    write_reg  = 5'd8;
    write_data = 32'hF0F0_F0F0;
    tick();
    write_reg  = 5'd9;
    write_data = 32'h0FF0_0FF0;
    tick();
    reg_write = 1'b0;
    read_reg1 = 5'd8;
    read_reg2 = 5'd9;
    #1;
    check("alu_a", read_data1, 32'hF0F0_F0F0);
    check("alu_b", read_data2, 32'h0FF0_0FF0);
    check("alu_and", read_data1 & read_data2, 32'h00F0_00F0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
